// File: rtl/conv_input_loader_if.sv
// Stream inputs (X and F) and memory write buses of the convolution input loader.
// slave = loader side, master = stream source / memory side.
interface conv_input_loader_if #(
    parameter int D_WIDTH          = 8,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2
);
    logic [D_WIDTH-1:0]          s_data_in_x;
    logic                        s_valid_x;
    logic                        s_ready_x;
    logic [D_WIDTH-1:0]          s_data_in_f;
    logic                        s_valid_f;
    logic                        s_ready_f;

    logic [X_MEM_ADDR_WIDTH-1:0] xmem_addr;
    logic                        xmem_wr_en;
    logic [D_WIDTH-1:0]          xmem_data;
    logic [F_MEM_ADDR_WIDTH-1:0] fmem_addr;
    logic                        fmem_wr_en;
    logic [D_WIDTH-1:0]          fmem_data;

    modport slave (
        input  s_data_in_x, s_valid_x, s_data_in_f, s_valid_f,
        output s_ready_x, s_ready_f,
        output xmem_addr, xmem_wr_en, xmem_data,
        output fmem_addr, fmem_wr_en, fmem_data
    );

    modport master (
        output s_data_in_x, s_valid_x, s_data_in_f, s_valid_f,
        input  s_ready_x, s_ready_f,
        input  xmem_addr, xmem_wr_en, xmem_data,
        input  fmem_addr, fmem_wr_en, fmem_data
    );
endinterface

// File: rtl/conv_input_loader.sv
// Loads X and F memories from two independent streams, then lends the address counters to the conv controller.
// Writes are same-cycle on handshake; conv_start 2 cycles after the last write; streams back-pressured while full or in CONV.
module conv_input_loader #(
    parameter int X_MEM_SIZE       = 8,
    parameter int F_MEM_SIZE       = 4,
    parameter int X_MEM_ADDR_WIDTH = 3,
    parameter int F_MEM_ADDR_WIDTH = 2,
    parameter int D_WIDTH          = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    conv_input_loader_if.slave          s,
    input  logic                        conv_done,
    input  logic                        load_xaddr,
    input  logic [X_MEM_ADDR_WIDTH-1:0] load_xaddr_val,
    input  logic                        en_xaddr_incr,
    input  logic                        load_faddr,
    input  logic                        en_faddr_incr,
    output logic                        conv_start
);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_LAST = X_MEM_ADDR_WIDTH'(X_MEM_SIZE - 1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_LAST = F_MEM_ADDR_WIDTH'(F_MEM_SIZE - 1);
    localparam logic [X_MEM_ADDR_WIDTH-1:0] X_ONE  = X_MEM_ADDR_WIDTH'(1);
    localparam logic [F_MEM_ADDR_WIDTH-1:0] F_ONE  = F_MEM_ADDR_WIDTH'(1);

    typedef enum logic {ST_LOAD, ST_CONV} state_t;

    state_t                      state_q, state_d;
    logic [X_MEM_ADDR_WIDTH-1:0] xaddr_q, xaddr_d;
    logic [F_MEM_ADDR_WIDTH-1:0] faddr_q, faddr_d;
    logic                        x_full_q, x_full_d;
    logic                        f_full_q, f_full_d;
    logic                        conv_start_q, conv_start_d;

    logic                        x_rdy, f_rdy, x_hs, f_hs;
    logic [D_WIDTH-1:0]          x_dat, f_dat;

    // Ready is a pure register decode so it never loops back through valid.
    assign x_rdy = (state_q == ST_LOAD) && !x_full_q;
    assign f_rdy = (state_q == ST_LOAD) && !f_full_q;
    assign x_hs  = s.s_valid_x && x_rdy;
    assign f_hs  = s.s_valid_f && f_rdy;
    assign x_dat = s.s_data_in_x;
    assign f_dat = s.s_data_in_f;

    assign s.s_ready_x  = x_rdy;
    assign s.s_ready_f  = f_rdy;
    assign s.xmem_wr_en = x_hs;
    assign s.fmem_wr_en = f_hs;
    assign s.xmem_data  = x_dat;
    assign s.fmem_data  = f_dat;
    assign s.xmem_addr  = xaddr_q;
    assign s.fmem_addr  = faddr_q;
    assign conv_start   = conv_start_q;

    always_comb begin
        state_d      = state_q;
        xaddr_d      = xaddr_q;
        faddr_d      = faddr_q;
        x_full_d     = x_full_q;
        f_full_d     = f_full_q;
        conv_start_d = conv_start_q;

        case (state_q)
            ST_LOAD: begin
                if (x_hs) begin
                    if (xaddr_q == X_LAST) begin
                        xaddr_d  = '0;
                        x_full_d = 1'b1;
                    end else begin
                        xaddr_d = xaddr_q + X_ONE;
                    end
                end
                if (f_hs) begin
                    if (faddr_q == F_LAST) begin
                        faddr_d  = '0;
                        f_full_d = 1'b1;
                    end else begin
                        faddr_d = faddr_q + F_ONE;
                    end
                end
                if (x_full_q && f_full_q) begin
                    state_d      = ST_CONV;
                    conv_start_d = 1'b1;
                end
            end
            default: begin
                if (conv_done) begin
                    state_d      = ST_LOAD;
                    conv_start_d = 1'b0;
                    xaddr_d      = '0;
                    faddr_d      = '0;
                    x_full_d     = 1'b0;
                    f_full_d     = 1'b0;
                end else begin
                    // Out-of-range load values fold to 0 so the counter stays inside the memory.
                    if (load_xaddr) begin
                        xaddr_d = (load_xaddr_val > X_LAST) ? '0 : load_xaddr_val;
                    end else if (en_xaddr_incr) begin
                        xaddr_d = (xaddr_q == X_LAST) ? '0 : xaddr_q + X_ONE;
                    end
                    if (load_faddr) begin
                        faddr_d = '0;
                    end else if (en_faddr_incr) begin
                        faddr_d = (faddr_q == F_LAST) ? '0 : faddr_q + F_ONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_LOAD;
            xaddr_q      <= '0;
            faddr_q      <= '0;
            x_full_q     <= 1'b0;
            f_full_q     <= 1'b0;
            conv_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            xaddr_q      <= xaddr_d;
            faddr_q      <= faddr_d;
            x_full_q     <= x_full_d;
            f_full_q     <= f_full_d;
            conv_start_q <= conv_start_d;
        end
    end
endmodule

// File: doc/conv_input_loader.md
Name: conv_input_loader

Overview:
- Upstream stage of the 1-D convolution datapath. Accepts the input vector X and filter F over two independent AXI-stream slave ports and writes them into the X and F memories.
- Owns the X and F address counters. During LOAD it drives them itself; during CONV it hands them to ctrl_conv_output through load/increment controls.
- Raises conv_start once both memories are full. Re-arms for the next vector when conv_done pulses.

Parameters:
- X_MEM_SIZE, 8, number of X words per convolution.
- F_MEM_SIZE, 4, number of filter taps.
- X_MEM_ADDR_WIDTH, 3, X address width; must be ≥ clog2(X_MEM_SIZE).
- F_MEM_ADDR_WIDTH, 2, F address width; must be ≥ clog2(F_MEM_SIZE).
- D_WIDTH, 8, data word width (signed).

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous active-high reset.
- s_data_in_x  in  D_WIDTH  X stream data.
- s_valid_x  in  1  X stream valid.
- s_ready_x  out  1  X stream ready.
- s_data_in_f  in  D_WIDTH  F stream data.
- s_valid_f  in  1  F stream valid.
- s_ready_f  out  1  F stream ready.
- conv_done  in  1  single-cycle pulse from ctrl_conv_output: last output accepted.
- load_xaddr  in  1  load X address counter with load_xaddr_val (CONV only).
- load_xaddr_val  in  X_MEM_ADDR_WIDTH  X counter load value.
- en_xaddr_incr  in  1  increment X address counter (CONV only).
- load_faddr  in  1  clear F address counter to 0 (CONV only).
- en_faddr_incr  in  1  increment F address counter (CONV only).
- xmem_addr  out  X_MEM_ADDR_WIDTH  X memory address (write and read).
- xmem_wr_en  out  1  X memory write enable.
- xmem_data  out  D_WIDTH  X memory write data.
- fmem_addr  out  F_MEM_ADDR_WIDTH  F memory address (also feeds ctrl_conv_output).
- fmem_wr_en  out  1  F memory write enable.
- fmem_data  out  D_WIDTH  F memory write data.
- conv_start  out  1  level: both memories loaded, convolution in progress.

Behaviour:
- Reset. Everything below holds in the cycle after reset is sampled high, regardless of the current state:
  - state = LOAD; xmem_addr = 0; fmem_addr = 0.
  - x_full = 0; f_full = 0; conv_start = 0.
  - s_ready_x = 1 and s_ready_f = 1 after reset deasserts.
  - Reset mid-stream or mid-convolution discards all partial state.
- State register: two states, LOAD and CONV.
- LOAD, X stream:
  - s_ready_x = !x_full, decoded from registers only; never depends on s_valid_x.
  - Handshake (s_valid_x & s_ready_x): xmem_wr_en = 1 combinationally and xmem_data = s_data_in_x in the same cycle.
  - On each handshake the X counter increments.
  - On the handshake at address X_MEM_SIZE-1: counter returns to 0 and x_full sets; s_ready_x is 0 from the next cycle.
  - Stalls (valid low) leave the counter unchanged.
- LOAD, F stream: identical, using f_full and F_MEM_SIZE-1.
- LOAD, general:
  - The two streams are fully independent. Either may finish first, and both may finish in the same cycle.
  - The CONV control inputs (load_*/en_*) are ignored.
  - conv_done is ignored.
- LOAD→CONV: when x_full & f_full are both registered high, the next edge sets state = CONV and conv_start = 1. Latency from the final write handshake to conv_start is 2 cycles.
- CONV, general:
  - s_ready_x = s_ready_f = 0; no writes (xmem_wr_en = fmem_wr_en = 0).
- CONV, X address counter:
  - load_xaddr has priority: counter ← load_xaddr_val.
  - Otherwise en_xaddr_incr: counter increments, wrapping from X_MEM_SIZE-1 to 0.
  - Otherwise hold.
- CONV, F address counter:
  - load_faddr has priority: counter ← 0.
  - Otherwise en_faddr_incr: counter increments, wrapping from F_MEM_SIZE-1 to 0.
  - Otherwise hold.
- CONV→LOAD: conv_done = 1 causes the following at the next edge; conv_done overrides any simultaneous load/incr request:
  - state = LOAD; conv_start = 0.
  - xmem_addr = 0; fmem_addr = 0.
  - x_full = 0; f_full = 0.
  - s_ready_* = 1 in the following cycle.
- Stream data arriving during CONV is back-pressured, never dropped.
- Addresses are unsigned; counters never exceed SIZE-1 in any state.

Test Plan:
- Reset, then stream X = 1..8 continuously, then F = 1..4 → 8 X writes at addresses 0..7 and 4 F writes at addresses 0..3. s_ready_x falls the cycle after the 8th X handshake. conv_start rises 2 cycles after the 4th F handshake.
- Interleaved random valid gaps on both streams, F completing first → s_ready_f stays 0 until conv_done. conv_start is not asserted until the 8th X write. Memory contents match the stimulus in order.
- CONV, pulse en_xaddr_incr ×3 then load_xaddr with load_xaddr_val = 5 → xmem_addr goes 0,1,2,3 then 5. Apply load_xaddr and en_xaddr_incr together → load wins.
- CONV, en_faddr_incr held high for 6 cycles → fmem_addr goes 0,1,2,3,0,1,2 (wrap). load_faddr → 0.
- conv_done pulse together with en_xaddr_incr at xmem_addr = 4 → next cycle xmem_addr = 0, conv_start = 0, s_ready_x = s_ready_f = 1. A second vector then loads correctly.
- reset asserted midway through X loading (addr = 3) and again mid-CONV → all outputs at reset values the next cycle. A full reload afterwards writes from address 0.
